// File: rtl/sram_port_ctrl.sv
// Request-side controller for a 1RW + 1R dual-port SRAM wrapper with two-cycle read latency.
// Optional build macro SRAM_CTRL_COLL_STALL_EN stalls port-B reads that collide with port-A writes.

module sram_rsp_chan #(
    parameter int WORD_SIZE = 32,
    parameter int TAG_LEN   = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_issue,
    input  logic [TAG_LEN-1:0]   rd_tag,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic                 credit_ok,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic [TAG_LEN-1:0]   rsp_tag
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    logic                 s1_valid_r;
    logic [TAG_LEN-1:0]   s1_tag_r;
    logic                 s2_valid_r;
    logic [TAG_LEN-1:0]   s2_tag_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [WORD_SIZE-1:0] mem_data_r [RSP_DEPTH];
    logic [TAG_LEN-1:0]   mem_tag_r  [RSP_DEPTH];
    logic [CNT_W:0]       occupancy_s;
    logic                 push_s;
    logic                 pop_s;

    // Every in-flight read owns a FIFO slot, so a push can never find the FIFO full.
    always_comb begin
        occupancy_s = {1'b0, count_r}
                    + {{CNT_W{1'b0}}, s1_valid_r}
                    + {{CNT_W{1'b0}}, s2_valid_r};
        credit_ok   = !rst && (occupancy_s < DEPTH_C);
        push_s      = s2_valid_r;
        rsp_valid   = (count_r != {CNT_W{1'b0}});
        pop_s       = rsp_valid && rsp_ready;
        rsp_data    = mem_data_r[rd_ptr_r];
        rsp_tag     = mem_tag_r[rd_ptr_r];
    end

    // Two-stage in-flight tracker matching the wrapper's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_tag_r   <= {TAG_LEN{1'b0}};
            s2_valid_r <= 1'b0;
            s2_tag_r   <= {TAG_LEN{1'b0}};
        end else begin
            s1_valid_r <= rd_issue;
            s1_tag_r   <= rd_tag;
            s2_valid_r <= s1_valid_r;
            s2_tag_r   <= s1_tag_r;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; entries are qualified by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= rdata;
            mem_tag_r[wr_ptr_r]  <= s2_tag_r;
        end
    end
endmodule

module sram_port_ctrl #(
    parameter int SIZE_IN_WORDS = 1024,
    parameter int WORD_SIZE     = 32,
    parameter int ADDR_LEN      = $clog2(SIZE_IN_WORDS),
    parameter int TAG_LEN       = 4,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reqA_valid,
    output logic                     reqA_ready,
    input  logic                     reqA_we,
    input  logic [ADDR_LEN-1:0]      reqA_addr,
    input  logic [WORD_SIZE-1:0]     reqA_wdata,
    input  logic [WORD_SIZE/8-1:0]   reqA_wmask,
    input  logic [TAG_LEN-1:0]       reqA_tag,
    output logic                     rspA_valid,
    input  logic                     rspA_ready,
    output logic [WORD_SIZE-1:0]     rspA_data,
    output logic [TAG_LEN-1:0]       rspA_tag,
    input  logic                     reqB_valid,
    output logic                     reqB_ready,
    input  logic [ADDR_LEN-1:0]      reqB_addr,
    input  logic [TAG_LEN-1:0]       reqB_tag,
    output logic                     rspB_valid,
    input  logic                     rspB_ready,
    output logic [WORD_SIZE-1:0]     rspB_data,
    output logic [TAG_LEN-1:0]       rspB_tag,
    output logic                     nce0,
    output logic                     nwe0,
    output logic [ADDR_LEN-1:0]      addr0,
    output logic [WORD_SIZE-1:0]     wdata0,
    output logic [WORD_SIZE/8-1:0]   wmask0,
    input  logic [WORD_SIZE-1:0]     rdata0,
    output logic                     nce1,
    output logic [ADDR_LEN-1:0]      addr1,
    input  logic [WORD_SIZE-1:0]     rdata1
);
    logic a_credit_s;
    logic b_credit_s;
    logic a_accept_s;
    logic a_rd_issue_s;
    logic b_accept_s;
    logic coll_stall_s;

    // Port A: writes need no response credit, reads do.
    always_comb begin
        reqA_ready   = !rst && (reqA_we || a_credit_s);
        a_accept_s   = reqA_valid && reqA_ready;
        a_rd_issue_s = a_accept_s && !reqA_we;
        nce0         = !a_accept_s;
        nwe0         = !(a_accept_s && reqA_we);
        addr0        = reqA_addr;
        wdata0       = reqA_wdata;
        wmask0       = reqA_wmask;
    end

`ifdef SRAM_CTRL_COLL_STALL_EN
    assign coll_stall_s = a_accept_s && reqA_we && (reqA_addr == reqB_addr);
`else
    assign coll_stall_s = 1'b0;
`endif

    // Port B: read-only, optionally held off by a same-address write on A.
    always_comb begin
        reqB_ready = b_credit_s && !coll_stall_s;
        b_accept_s = reqB_valid && reqB_ready;
        nce1       = !b_accept_s;
        addr1      = reqB_addr;
    end

    sram_rsp_chan #(
        .WORD_SIZE (WORD_SIZE),
        .TAG_LEN   (TAG_LEN),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (a_rd_issue_s),
        .rd_tag    (reqA_tag),
        .rdata     (rdata0),
        .credit_ok (a_credit_s),
        .rsp_valid (rspA_valid),
        .rsp_ready (rspA_ready),
        .rsp_data  (rspA_data),
        .rsp_tag   (rspA_tag)
    );

    sram_rsp_chan #(
        .WORD_SIZE (WORD_SIZE),
        .TAG_LEN   (TAG_LEN),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (b_accept_s),
        .rd_tag    (reqB_tag),
        .rdata     (rdata1),
        .credit_ok (b_credit_s),
        .rsp_valid (rspB_valid),
        .rsp_ready (rspB_ready),
        .rsp_data  (rspB_data),
        .rsp_tag   (rspB_tag)
    );
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: directed steps plus randomized traffic against
// a golden-memory / outstanding-request scoreboard. Honours SRAM_CTRL_COLL_STALL_EN.

module tb_sram_port_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int MW = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic reqA_valid, reqA_ready, reqA_we;
    logic [AW-1:0] reqA_addr;
    logic [DW-1:0] reqA_wdata;
    logic [MW-1:0] reqA_wmask;
    logic [TW-1:0] reqA_tag;
    logic rspA_valid, rspA_ready;
    logic [DW-1:0] rspA_data;
    logic [TW-1:0] rspA_tag;
    logic reqB_valid, reqB_ready;
    logic [AW-1:0] reqB_addr;
    logic [TW-1:0] reqB_tag;
    logic rspB_valid, rspB_ready;
    logic [DW-1:0] rspB_data;
    logic [TW-1:0] rspB_tag;
    logic nce0, nwe0, nce1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, rdata0, rdata1;
    logic [MW-1:0] wmask0;

    sram_port_ctrl #(
        .SIZE_IN_WORDS(1024), .WORD_SIZE(DW), .ADDR_LEN(AW), .TAG_LEN(TW), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .reqA_valid(reqA_valid), .reqA_ready(reqA_ready), .reqA_we(reqA_we),
        .reqA_addr(reqA_addr), .reqA_wdata(reqA_wdata), .reqA_wmask(reqA_wmask), .reqA_tag(reqA_tag),
        .rspA_valid(rspA_valid), .rspA_ready(rspA_ready), .rspA_data(rspA_data), .rspA_tag(rspA_tag),
        .reqB_valid(reqB_valid), .reqB_ready(reqB_ready), .reqB_addr(reqB_addr), .reqB_tag(reqB_tag),
        .rspB_valid(rspB_valid), .rspB_ready(rspB_ready), .rspB_data(rspB_data), .rspB_tag(rspB_tag),
        .nce0(nce0), .nwe0(nwe0), .addr0(addr0), .wdata0(wdata0), .wmask0(wmask0), .rdata0(rdata0),
        .nce1(nce1), .addr1(addr1), .rdata1(rdata1)
    );

    // SRAM wrapper model: address sampled at the edge, data two cycles later.
    logic [DW-1:0] sram [0:1023];
    logic [DW-1:0] p0_q, p1_q;
    always @(posedge clk) begin
        if (!nce0) begin
            if (!nwe0) begin
                for (int i = 0; i < MW; i++)
                    if (wmask0[i]) sram[addr0][8*i +: 8] <= wdata0[8*i +: 8];
            end else begin
                p0_q <= sram[addr0];
            end
        end
        rdata0 <= p0_q;
        if (!nce1) p1_q <= sram[addr1];
        rdata1 <= p1_q;
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        bit            chk_data;
        int            cyc;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    logic [DW-1:0] gold [0:1023];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int idx, nb0, n_rsp_b = 0, last_rsp_b_cyc = 0, prev_rsp_b_cyc = 0;
    bit last_va, last_ra, last_rb, last_acc_b;
    logic [DW-1:0] last_da, last_pop_db, prev_pop_db;
    logic [TW-1:0] last_ta;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, update the model, return just after the rising edge.
    task automatic cycle();
        ent_t e;
        bit acc_a, acc_b, exp_ra, exp_rb, coll;
        logic [DW-1:0] w;
        acc_a = 1'b0;
        acc_b = 1'b0;
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("rst_nce0", nce0, 1'b1);
            chk("rst_nce1", nce1, 1'b1);
            chk("rst_nwe0", nwe0, 1'b1);
            chk("rst_readyA", reqA_ready, 1'b0);
            chk("rst_readyB", reqB_ready, 1'b0);
            chk("rst_rspA_valid", rspA_valid, 1'b0);
            chk("rst_rspB_valid", rspB_valid, 1'b0);
        end else begin
            coll   = reqA_valid && reqA_we && (reqA_addr == reqB_addr);
            exp_ra = reqA_we || (qa.size() < DEPTH);
            exp_rb = (qb.size() < DEPTH);
`ifdef SRAM_CTRL_COLL_STALL_EN
            if (coll) exp_rb = 1'b0;
`endif
            chk("readyA", reqA_ready, exp_ra);
            chk("readyB", reqB_ready, exp_rb);
            chk("nce0", nce0, !(reqA_valid && exp_ra));
            chk("nwe0", nwe0, !(reqA_valid && exp_ra && reqA_we));
            chk("nce1", nce1, !(reqB_valid && exp_rb));
            acc_a = reqA_valid && reqA_ready;
            acc_b = reqB_valid && reqB_ready;
            if (rspA_valid) begin
                chk("rspA_expected", qa.size() != 0, 1'b1);
                if (qa.size() != 0) begin
                    chk("rspA_latency", cyc >= qa[0].cyc + 3, 1'b1);
                    if (rspA_ready) begin
                        e = qa.pop_front();
                        chk("rspA_tag", rspA_tag, e.tag);
                        if (e.chk_data) chk("rspA_data", rspA_data, e.data);
                    end
                end
            end
            if (rspB_valid) begin
                chk("rspB_expected", qb.size() != 0, 1'b1);
                if (qb.size() != 0) begin
                    chk("rspB_latency", cyc >= qb[0].cyc + 3, 1'b1);
                    if (rspB_ready) begin
                        e = qb.pop_front();
                        chk("rspB_tag", rspB_tag, e.tag);
                        if (e.chk_data) chk("rspB_data", rspB_data, e.data);
                        n_rsp_b++;
                        prev_rsp_b_cyc = last_rsp_b_cyc;
                        last_rsp_b_cyc = cyc;
                        prev_pop_db = last_pop_db;
                        last_pop_db = rspB_data;
                    end
                end
            end
            if (acc_a && !reqA_we) qa.push_back('{reqA_tag, gold[reqA_addr], 1'b1, cyc});
            if (acc_b) qb.push_back('{reqB_tag, gold[reqB_addr], !(coll && acc_a), cyc});
            if (acc_a && reqA_we) begin
                w = gold[reqA_addr];
                for (int i = 0; i < MW; i++)
                    if (reqA_wmask[i]) w[8*i +: 8] = reqA_wdata[8*i +: 8];
                gold[reqA_addr] = w;
            end
        end
        last_va = rspA_valid;
        last_da = rspA_data;
        last_ta = rspA_tag;
        last_ra = reqA_ready;
        last_rb = reqB_ready;
        last_acc_b = acc_b;
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        reqA_valid = 1'b1; reqA_we = 1'b1; reqA_addr = a; reqA_wdata = d; reqA_wmask = m;
        cycle();
        reqA_valid = 1'b0; reqA_we = 1'b0;
    endtask

    task automatic drain(input int budget);
        reqA_valid = 1'b0; reqB_valid = 1'b0; rspA_ready = 1'b1; rspB_ready = 1'b1;
        for (int k = 0; k < budget && (qa.size() + qb.size()) != 0; k++) cycle();
        chk("drain_empty", qa.size() + qb.size(), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        reqA_valid = 1'b1; reqA_we = 1'b0; reqA_addr = '0; reqA_wdata = '0; reqA_wmask = '0; reqA_tag = '0;
        reqB_valid = 1'b1; reqB_addr = '0; reqB_tag = '0;
        rspA_ready = 1'b0; rspB_ready = 1'b0;
        cycle();
        cycle();
        reqA_we = 1'b1;
        cycle();
        reqA_valid = 1'b0; reqB_valid = 1'b0; reqA_we = 1'b0; rst = 1'b0;
        cycle();
        chk("release_readyA", last_ra, 1'b1);
        chk("release_readyB", last_rb, 1'b1);

        // write then read on A: response first valid three cycles after the read
        rspA_ready = 1'b1; rspB_ready = 1'b1;
        a_write(10'h005, 32'hDEADBEEF, 4'hF);
        reqA_valid = 1'b1; reqA_we = 1'b0; reqA_addr = 10'h005; reqA_tag = 4'd3;
        cycle();
        reqA_valid = 1'b0;
        cycle(); chk("wr_rd_c2_valid", last_va, 1'b0);
        cycle(); chk("wr_rd_c3_valid", last_va, 1'b0);
        cycle(); chk("wr_rd_c4_valid", last_va, 1'b1);
        chk("wr_rd_data", last_da, 32'hDEADBEEF);
        chk("wr_rd_tag", last_ta, 4'd3);

        // byte mask merge read back on B
        a_write(10'h020, 32'h11223344, 4'hF);
        a_write(10'h020, 32'hAABBCCDD, 4'h5);
        reqB_valid = 1'b1; reqB_addr = 10'h020; reqB_tag = 4'd5;
        cycle();
        drain(20);
        chk("mask_data", last_pop_db, 32'h11BB33DD);

        // backpressure on B: four credits, then all eight in order
        for (int i = 0; i < 8; i++) a_write(AW'(i), $urandom(), 4'hF);
        rspB_ready = 1'b0; idx = 0; reqB_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            reqB_addr = AW'(idx); reqB_tag = TW'(idx);
            cycle();
            if (last_acc_b) idx++;
        end
        chk("bp_accepted", idx, 64'd4);
        chk("bp_ready_low", last_rb, 1'b0);
        rspB_ready = 1'b1; nb0 = n_rsp_b;
        for (int k = 0; k < 60 && (idx < 8 || qb.size() != 0); k++) begin
            reqB_valid = (idx < 8);
            reqB_addr = AW'(idx); reqB_tag = TW'(idx);
            cycle();
            if (last_acc_b) idx++;
        end
        reqB_valid = 1'b0;
        chk("bp_all_issued", idx, 64'd8);
        chk("bp_rsp_count", n_rsp_b - nb0, 64'd8);

        // boundary addresses back to back
        a_write(10'h1FF, 32'h1FF0A5A5, 4'hF);
        a_write(10'h200, 32'h20005A5A, 4'hF);
        reqB_valid = 1'b1; reqB_addr = 10'h1FF; reqB_tag = 4'd1;
        cycle();
        reqB_addr = 10'h200; reqB_tag = 4'd2;
        cycle();
        drain(20);
        chk("bank_gap", last_rsp_b_cyc - prev_rsp_b_cyc, 64'd1);
        chk("bank_data_lo", prev_pop_db, 32'h1FF0A5A5);
        chk("bank_data_hi", last_pop_db, 32'h20005A5A);

        // same-address A write and B read
        a_write(10'h010, 32'h00000001, 4'hF);
        reqA_valid = 1'b1; reqA_we = 1'b1; reqA_addr = 10'h010; reqA_wdata = 32'hC0111DE5; reqA_wmask = 4'hF;
        reqB_valid = 1'b1; reqB_addr = 10'h010; reqB_tag = 4'd9;
        cycle();
        chk("coll_a_ready", last_ra, 1'b1);
`ifdef SRAM_CTRL_COLL_STALL_EN
        chk("coll_b_stalled", last_rb, 1'b0);
        reqA_valid = 1'b0; reqA_we = 1'b0;
        cycle();
        chk("coll_b_retry", last_acc_b, 1'b1);
        drain(20);
        chk("coll_b_data", last_pop_db, 32'hC0111DE5);
`else
        chk("coll_b_accepted", last_rb, 1'b1);
        drain(20);
`endif
        reqB_valid = 1'b1; reqB_addr = 10'h010; reqB_tag = 4'd10;
        cycle();
        drain(20);
        chk("coll_readback", last_pop_db, 32'hC0111DE5);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 32; i++) a_write(AW'(i), $urandom(), 4'hF);
        for (int k = 0; k < 400; k++) begin
            reqA_valid = ($urandom_range(0, 3) != 0);
            reqA_we    = ($urandom_range(0, 1) != 0);
            reqA_addr  = AW'($urandom_range(0, 31));
            reqA_wdata = $urandom();
            reqA_wmask = MW'($urandom_range(0, 15));
            reqA_tag   = TW'($urandom_range(0, 15));
            reqB_valid = ($urandom_range(0, 3) != 0);
            reqB_addr  = AW'($urandom_range(0, 31));
            reqB_tag   = TW'($urandom_range(0, 15));
            rspA_ready = ($urandom_range(0, 3) != 0);
            rspB_ready = ($urandom_range(0, 3) != 0);
            if (k == 200) begin
                rst = 1'b1;
                qa.delete();
                qb.delete();
            end
            if (k == 203) rst = 1'b0;
            cycle();
        end
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Request-side controller for the dual-port SRAM wrapper: one read/write port plus one read-only port. It turns valid/ready load/store requests into active-low SRAM strobes and tracks each read through the wrapper's fixed two-cycle read latency. Read data and tags return on valid/ready response channels, buffered in per-port response FIFOs whose credits guarantee no read data is ever dropped. Sits between the core's memory units and the SRAM wrapper instance.

## Interface

Parameters:
- SIZE_IN_WORDS, 1024: SRAM depth in words; must match the wrapper.
- WORD_SIZE, 32: data width; multiple of 8.
- ADDR_LEN, $clog2(SIZE_IN_WORDS): word address width.
- TAG_LEN, 4: request tag width, returned unchanged with read data.
- RSP_DEPTH, 4: entries per response FIFO; power of 2, >= 2.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- reqA_valid  in  1  port A request valid.
- reqA_ready  out  1  port A request accepted when valid && ready.
- reqA_we  in  1  1 = write, 0 = read.
- reqA_addr  in  ADDR_LEN  word address.
- reqA_wdata  in  WORD_SIZE  write data.
- reqA_wmask  in  WORD_SIZE/8  byte enables; bit i covers byte i (LSB byte = bit 0).
- reqA_tag  in  TAG_LEN  read tag.
- rspA_valid  out  1  port A read response valid.
- rspA_ready  in  1  consumer accepts response.
- rspA_data  out  WORD_SIZE  read data.
- rspA_tag  out  TAG_LEN  tag of the request.
- reqB_valid, reqB_ready, reqB_addr, reqB_tag: as port A, read-only.
- rspB_valid, rspB_ready, rspB_data, rspB_tag: as port A.
- nce0  out  1  SRAM port 0 chip enable, active low.
- nwe0  out  1  SRAM port 0 write enable, active low.
- addr0  out  ADDR_LEN  SRAM port 0 address.
- wdata0  out  WORD_SIZE  SRAM port 0 write data.
- wmask0  out  WORD_SIZE/8  SRAM port 0 byte mask.
- rdata0  in  WORD_SIZE  SRAM port 0 read data.
- nce1  out  1  SRAM port 1 chip enable, active low.
- addr1  out  ADDR_LEN  SRAM port 1 address.
- rdata1  in  WORD_SIZE  SRAM port 1 read data.

## Operation

- SRAM strobes are combinational from the handshake:
  - nce0 = !(reqA_valid && reqA_ready); nwe0 = !(accepted && reqA_we).
  - nce1 = !(reqB_valid && reqB_ready).
  - addr, wdata and wmask pass through unchanged.
- Per-port two-stage in-flight pipeline (s1, s2), each stage holding a valid bit and a tag:
  - An accepted read loads s1; s1 shifts to s2 every cycle.
  - When s2 is valid, rdataN is pushed into the port's FIFO together with the s2 tag.
- Credit rule for reads: ready = !rst && (fifo_count + s1.valid + s2.valid < RSP_DEPTH).
- Writes on port A are ready whenever !rst. They produce no response.
- FIFO: rsp*_valid = !empty, output fields come from the head entry, pop on valid && ready. Push and pop in the same cycle leave count unchanged.
- Responses return in request order within a port. Ports A and B are fully independent.
- Reset: s1/s2 invalid, FIFOs empty, rsp*_valid = 0, req*_ready = 0, nce0 = nce1 = nwe0 = 1. Reset mid-operation discards in-flight reads and buffered responses.

## Timing

- Read accepted in cycle c:
  - SRAM samples the address at the end of c.
  - rdata is valid in cycle c+2 and pushed to the FIFO at the end of c+2.
  - rsp*_valid rises in c+3 at the earliest.
- Write accepted in cycle c is visible to a read accepted in c+1 or later.
- Throughput is one read per cycle per port with rsp*_ready held high, when RSP_DEPTH >= 4.
- FIFO full plus two reads in flight forces ready low. No read data is ever dropped.

## Configuration

- SRAM_CTRL_COLL_STALL_EN defined:
  - reqB_ready is additionally forced low in any cycle where port A accepts a write with reqA_addr == reqB_addr.
  - The B read issues in a later cycle and returns the new data.
- Undefined:
  - No collision check; both requests issue.
  - rspB_data for the colliding read is undefined.

## Test plan

- Reset: hold rst = 1 with reqA_valid = reqB_valid = 1 -> nce0 = nce1 = nwe0 = 1, both readys 0, both rsp valids 0; one cycle after release readys = 1.
- Write/read: A write addr 0x005, data 0xDEADBEEF, mask 0xF in cycle 0; A read addr 0x005, tag 3 in cycle 1 -> rspA_valid first high in cycle 4 with data 0xDEADBEEF, tag 3.
- Byte mask: write 0x11223344 with mask 0xF, then 0xAABBCCDD with mask 0x5, to addr 0x020; read on B -> 0x11BB33DD.
- Backpressure: rspB_ready = 0, reqB_valid held with addr 0..7, tags 0..7 -> exactly 4 accepted, then reqB_ready = 0; release rspB_ready -> all 8 responses in tag order with correct data, none lost.
- Bank boundary: back-to-back B reads of 0x1FF then 0x200 after writing distinct values -> both return correct data in consecutive cycles.
- Collision: A write 0x010 and B read 0x010 in the same cycle -> with SRAM_CTRL_COLL_STALL_EN, reqB_ready = 0 that cycle and B later returns the written data; without it, both are accepted.
